// File: rtl/k052109_pkg.sv
// Shared types and constants for the K052109 VRAM access scheduler.
package k052109_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned NBANK  = 3;

  // Slot ownership order within a character cell
  typedef enum logic [1:0] {
    SLOT_LA  = 2'd0,
    SLOT_LB  = 2'd1,
    SLOT_FX  = 2'd2,
    SLOT_CPU = 2'd3
  } slot_e;

  // Who actually uses the current slot once FETCH_EN and the pending request are known
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_CPU   = 2'd2
  } own_e;

  // Phase within a slot
  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_ACC  = 2'd1;
  localparam logic [1:0] PH_LAT  = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  // Inactive / active strobe levels (all active-low)
  localparam logic [1:0]       RCS_OFF = 2'b11;
  localparam logic [1:0]       RCS_ON  = 2'b00;
  localparam logic [NBANK-1:0] ROE_OFF = 3'b111;
  localparam logic [NBANK-1:0] RWE_OFF = 3'b111;
  localparam logic [NBANK-1:0] ROE_ALL = 3'b000;

  // Captured CPU access
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
  } cpu_req_t;

  // Active-low one-hot bank enable; bank 3 selects nothing
  function automatic logic [NBANK-1:0] bank_en_n(input logic [BANK_W-1:0] bank);
    logic [NBANK-1:0] en_n;
    case (bank)
      2'd0:    en_n = 3'b110;
      2'd1:    en_n = 3'b101;
      2'd2:    en_n = 3'b011;
      default: en_n = 3'b111;
    endcase
    return en_n;
  endfunction

endpackage

// File: rtl/k052109_cpu_req.sv
// CPU request edge detector and single-entry pending register.
module k052109_cpu_req
  import k052109_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     req_i,
  input  cpu_req_t req_data_i,
  input  logic     clr_i,
  output logic     pend_valid_o,
  output cpu_req_t pend_o
);

  logic     req_prev_q;
  logic     valid_q, valid_d;
  cpu_req_t data_q, data_d;
  logic     rise;

  // Reset primes the edge detector high so a request held across reset is not taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_prev_q <= 1'b1;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      req_prev_q <= req_i;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  // Capture only into an empty register; completion clears it
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rise    = req_i & ~req_prev_q;
    if (valid_q) begin
      if (clr_i) begin
        valid_d = 1'b0;
      end
    end else if (rise) begin
      valid_d = 1'b1;
      data_d  = req_data_i;
    end
  end

  assign pend_valid_o = valid_q;
  assign pend_o       = data_q;

endmodule

// File: rtl/k052109_vram_sched.sv
// K052109 VRAM slot scheduler: cell counter, slot ownership and strobe decode.
// Outputs are registered from the next counter value so they line up with SLOT.
module k052109_vram_sched
  import k052109_pkg::*;
#(
  parameter int unsigned CELL_LEN = 16,
  parameter int unsigned SLOT_LEN = 4
) (
  input  logic              M24,
  input  logic              RES,
  input  logic              CELL_SYNC,
  input  logic              FETCH_EN,
  input  logic [ADDR_W-1:0] LA_ADDR,
  input  logic [ADDR_W-1:0] LB_ADDR,
  input  logic [ADDR_W-1:0] FX_ADDR,
  input  logic              CPU_REQ,
  input  logic              CPU_WR,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [BANK_W-1:0] CPU_BANK,
  output logic [ADDR_W-1:0] RA,
  output logic [1:0]        RCS,
  output logic [NBANK-1:0]  ROE,
  output logic [NBANK-1:0]  RWE,
  output logic              LA_LAT,
  output logic              LB_LAT,
  output logic              FX_LAT,
  output logic              CPU_LAT,
  output logic              CPU_ACK,
  output logic [1:0]        SLOT
);

  localparam int unsigned CNT_W = $clog2(CELL_LEN);
  localparam int unsigned PH_W  = $clog2(SLOT_LEN);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  own_e              own_q, own_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [1:0]        rcs_q, rcs_d;
  logic [NBANK-1:0]  roe_q, roe_d;
  logic [NBANK-1:0]  rwe_q, rwe_d;
  logic              la_lat_q, la_lat_d;
  logic              lb_lat_q, lb_lat_d;
  logic              fx_lat_q, fx_lat_d;
  logic              cpu_lat_q, cpu_lat_d;
  logic              ack_q, ack_d;

  logic [1:0]        ph_d;
  slot_e             sl_d;
  logic              pend_valid;
  cpu_req_t          pend;
  cpu_req_t          cpu_in;

  assign cpu_in = {CPU_WR, CPU_ADDR, CPU_BANK};

  // Pending CPU access; cleared on the edge that raises CPU_ACK
  k052109_cpu_req u_cpu_req (
    .clk_i        (M24),
    .rst_ni       (RES),
    .req_i        (CPU_REQ),
    .req_data_i   (cpu_in),
    .clr_i        (ack_d),
    .pend_valid_o (pend_valid),
    .pend_o       (pend)
  );

  // State and output registers; reset drops every enable asynchronously.
  // The first slot after reset is treated as an LA fetch.
  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      cnt_q     <= '0;
      own_q     <= OWN_FETCH;
      ra_q      <= '0;
      rcs_q     <= RCS_OFF;
      roe_q     <= ROE_OFF;
      rwe_q     <= RWE_OFF;
      la_lat_q  <= 1'b0;
      lb_lat_q  <= 1'b0;
      fx_lat_q  <= 1'b0;
      cpu_lat_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      ra_q      <= ra_d;
      rcs_q     <= rcs_d;
      roe_q     <= roe_d;
      rwe_q     <= rwe_d;
      la_lat_q  <= la_lat_d;
      lb_lat_q  <= lb_lat_d;
      fx_lat_q  <= fx_lat_d;
      cpu_lat_q <= cpu_lat_d;
      ack_q     <= ack_d;
    end
  end

  // Next counter, slot ownership at phase 0, and strobe decode for the coming cycle.
  // CELL_SYNC forces phase 0 next, which also aborts any access in flight.
  always_comb begin
    cnt_d     = CELL_SYNC ? '0 : cnt_q + CNT_W'(1);
    ph_d      = 2'(cnt_d[PH_W-1:0]);
    sl_d      = slot_e'(2'(cnt_d >> PH_W));
    own_d     = own_q;
    ra_d      = ra_q;
    rcs_d     = RCS_OFF;
    roe_d     = ROE_OFF;
    rwe_d     = RWE_OFF;
    la_lat_d  = 1'b0;
    lb_lat_d  = 1'b0;
    fx_lat_d  = 1'b0;
    cpu_lat_d = 1'b0;
    ack_d     = 1'b0;

    if (ph_d == PH_ADDR) begin
      if (sl_d == SLOT_CPU || !FETCH_EN) begin
        own_d = pend_valid ? OWN_CPU : OWN_IDLE;
      end else begin
        own_d = OWN_FETCH;
      end
      case (own_d)
        OWN_FETCH: begin
          case (sl_d)
            SLOT_LA: ra_d = LA_ADDR;
            SLOT_LB: ra_d = LB_ADDR;
            default: ra_d = FX_ADDR;
          endcase
        end
        OWN_CPU: ra_d = pend.addr;
        default: ra_d = ra_q;
      endcase
    end

    if ((ph_d == PH_ACC || ph_d == PH_LAT) && own_d != OWN_IDLE) begin
      rcs_d = RCS_ON;
      if (own_d == OWN_FETCH) begin
        roe_d = ROE_ALL;
      end else if (pend.wr) begin
        rwe_d = bank_en_n(pend.bank);
      end else begin
        roe_d = bank_en_n(pend.bank);
      end
    end

    if (ph_d == PH_LAT) begin
      if (own_d == OWN_FETCH) begin
        la_lat_d = (sl_d == SLOT_LA);
        lb_lat_d = (sl_d == SLOT_LB);
        fx_lat_d = (sl_d == SLOT_FX);
      end else if (own_d == OWN_CPU) begin
        cpu_lat_d = 1'b1;
      end
    end

    if (ph_d == PH_DONE && own_d == OWN_CPU) begin
      ack_d = 1'b1;
    end
  end

  assign RA      = ra_q;
  assign RCS     = rcs_q;
  assign ROE     = roe_q;
  assign RWE     = rwe_q;
  assign LA_LAT  = la_lat_q;
  assign LB_LAT  = lb_lat_q;
  assign FX_LAT  = fx_lat_q;
  assign CPU_LAT = cpu_lat_q;
  assign CPU_ACK = ack_q;
  assign SLOT    = 2'(cnt_q >> PH_W);

endmodule

// File: tb/tb_k052109_vram_sched.sv
// Directed bench for the K052109 VRAM scheduler.
module tb_k052109_vram_sched;

  logic        M24, RES, CELL_SYNC, FETCH_EN;
  logic [12:0] LA_ADDR, LB_ADDR, FX_ADDR;
  logic        CPU_REQ, CPU_WR;
  logic [12:0] CPU_ADDR;
  logic [1:0]  CPU_BANK;
  logic [12:0] RA;
  logic [1:0]  RCS;
  logic [2:0]  ROE, RWE;
  logic        LA_LAT, LB_LAT, FX_LAT, CPU_LAT, CPU_ACK;
  logic [1:0]  SLOT;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  k052109_vram_sched #(.CELL_LEN(16), .SLOT_LEN(4)) dut (
    .M24(M24), .RES(RES), .CELL_SYNC(CELL_SYNC), .FETCH_EN(FETCH_EN),
    .LA_ADDR(LA_ADDR), .LB_ADDR(LB_ADDR), .FX_ADDR(FX_ADDR),
    .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR), .CPU_BANK(CPU_BANK),
    .RA(RA), .RCS(RCS), .ROE(ROE), .RWE(RWE),
    .LA_LAT(LA_LAT), .LB_LAT(LB_LAT), .FX_LAT(FX_LAT), .CPU_LAT(CPU_LAT),
    .CPU_ACK(CPU_ACK), .SLOT(SLOT)
  );

  initial begin
    M24 = 1'b0;
    forever #5 M24 = ~M24;
  end

  function automatic logic [31:0] vec();
    return {4'b0, RA, RCS, ROE, RWE, LA_LAT, LB_LAT, FX_LAT, CPU_LAT, CPU_ACK, SLOT};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; pos tracks the expected cell counter
  task automatic step();
    logic cs;
    cs = CELL_SYNC;
    @(posedge M24);
    #1;
    pos = cs ? 0 : (pos + 1) % 16;
  endtask

  task automatic step_to(input int p);
    for (int i = 0; i < 40; i++) begin
      if (pos == p) break;
      step();
    end
  endtask

  task automatic raise(input logic wr, input logic [12:0] a, input logic [1:0] b);
    CPU_WR   = wr;
    CPU_ADDR = a;
    CPU_BANK = b;
    CPU_REQ  = 1'b1;
  endtask

  logic [31:0] rst_vec, exp;
  logic [12:0] ra_e;
  logic [3:0]  lat_e;
  logic        acc;
  int          ph, sl;

  initial begin
    RES = 1'b0; CELL_SYNC = 1'b0; FETCH_EN = 1'b1;
    LA_ADDR = 13'h0100; LB_ADDR = 13'h0900; FX_ADDR = 13'h1100;
    CPU_REQ = 1'b1; CPU_WR = 1'b0; CPU_ADDR = 13'h0555; CPU_BANK = 2'd0;
    rst_vec = {4'b0, 13'h0, 2'b11, 3'b111, 3'b111, 4'b0, 1'b0, 2'b0};

    // Reset state, CPU_REQ held high through release
    repeat (3) @(posedge M24);
    #1;
    chk("reset", vec(), rst_vec);
    RES = 1'b1;
    pos = 0;

    // Fetch-only pattern over two and a quarter cells
    for (int c = 0; c < 36; c++) begin
      if (c > 0) step();
      ph  = c % 4;
      sl  = (c / 4) % 4;
      acc = (sl < 3) && (ph == 1 || ph == 2);
      if (c < 4)        ra_e = 13'h0;
      else if (sl == 0) ra_e = 13'h0100;
      else if (sl == 1) ra_e = 13'h0900;
      else              ra_e = 13'h1100;
      lat_e = 4'b0;
      if (ph == 2 && sl < 3) lat_e = 4'b1000 >> sl;
      exp = {4'b0, ra_e, acc ? 2'b00 : 2'b11, acc ? 3'b000 : 3'b111, 3'b111,
             lat_e, 1'b0, 2'(sl)};
      chk($sformatf("fetch_c%0d", c), vec(), exp);
    end
    CPU_REQ = 1'b0;

    // CPU write bank 1 raised at cycle 5
    step_to(5);
    raise(1'b1, 13'h1ABC, 2'd1);
    step_to(12); chk("wr_ra", 32'(RA), 32'h1ABC);
    chk("wr_ra_rwe", 32'(RWE), 32'h7);
    step();      chk("wr_rwe13", 32'({RCS, ROE, RWE}), 32'({2'b00, 3'b111, 3'b101}));
    step();      chk("wr_rwe14", 32'({RWE, CPU_LAT, CPU_ACK}), 32'({3'b101, 1'b1, 1'b0}));
    step();      chk("wr_ack15", 32'({RWE, CPU_ACK}), 32'({3'b111, 1'b1}));
    step();      chk("wr_ack_off", 32'(CPU_ACK), 32'h0);
    CPU_REQ = 1'b0;
    step_to(13); chk("wr_once", 32'(RWE), 32'h7);
    step_to(15); chk("wr_noack2", 32'(CPU_ACK), 32'h0);

    // Blanking: idle slot 0, CPU read bank 2 served in slot 1
    FETCH_EN = 1'b0;
    step(); step();
    chk("blank_idle1", 32'({RCS, ROE}), 32'({2'b11, 3'b111}));
    raise(1'b0, 13'h0333, 2'd2);
    step_to(4);  chk("rd_ra", 32'({RA, SLOT}), 32'({13'h0333, 2'd1}));
    step();      chk("rd_roe5", 32'({ROE, RWE}), 32'({3'b011, 3'b111}));
    step();      chk("rd_lat6", 32'({LB_LAT, CPU_LAT}), 32'({1'b0, 1'b1}));
    step();      chk("rd_ack7", 32'(CPU_ACK), 32'h1);
    CPU_REQ = 1'b0;
    step_to(9);  chk("blank_idle9", 32'({RCS, ROE}), 32'({2'b11, 3'b111}));

    // Second rise while pending is ignored
    FETCH_EN = 1'b1;
    raise(1'b0, 13'h0FFF, 2'd0);
    step();      CPU_REQ = 1'b0;
    step();      raise(1'b1, 13'h0001, 2'd1);
    step();      chk("dup_ra", 32'(RA), 32'h0FFF);
    step();      chk("dup_roe", 32'({ROE, RWE}), 32'({3'b110, 3'b111}));
    step_to(15); chk("dup_ack", 32'(CPU_ACK), 32'h1);
    step_to(12); chk("dup_ra2", 32'(RA), 32'h1100);
    step();      chk("dup_en2", 32'({ROE, RWE}), 32'({3'b111, 3'b111}));
    step_to(15); chk("dup_noack2", 32'(CPU_ACK), 32'h0);
    CPU_REQ = 1'b0;

    // CELL_SYNC at cycle 13 aborts, retried next cell
    step_to(2);  raise(1'b0, 13'h0A0A, 2'd0);
    step_to(12); chk("abort_ra", 32'(RA), 32'h0A0A);
    step();      chk("abort_roe", 32'(ROE), 32'h6);
    CELL_SYNC = 1'b1;
    step();
    CELL_SYNC = 1'b0;
    chk("abort_off", 32'({RA, RCS, ROE, CPU_ACK, SLOT}),
        32'({13'h0100, 2'b11, 3'b111, 1'b0, 2'd0}));
    step();      chk("abort_fetch", 32'(ROE), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("abort_noack_p%0d", pos), 32'(CPU_ACK), 32'h0);
    end
    step();      chk("retry_ra", 32'(RA), 32'h0A0A);
    step();      chk("retry_roe", 32'(ROE), 32'h6);
    step();      chk("retry_lat", 32'(CPU_LAT), 32'h1);
    step();      chk("retry_ack", 32'(CPU_ACK), 32'h1);
    CPU_REQ = 1'b0;

    // Capture on slot-3 phase-0 edge waits a cell; bank 3 asserts no enables
    step_to(11); raise(1'b1, 13'h0222, 2'd3);
    step();      chk("late_ra", 32'(RA), 32'h1100);
    step_to(15); chk("late_noack", 32'(CPU_ACK), 32'h0);
    step_to(12); chk("b3_ra", 32'(RA), 32'h0222);
    step();      chk("b3_en", 32'({ROE, RWE}), 32'({3'b111, 3'b111}));
    step();      chk("b3_lat", 32'(CPU_LAT), 32'h1);
    step();      chk("b3_ack", 32'(CPU_ACK), 32'h1);
    CPU_REQ = 1'b0;
    step_to(12); chk("b3_clr_ra", 32'(RA), 32'h1100);
    step_to(15); chk("b3_clr_ack", 32'(CPU_ACK), 32'h0);

    // Reset in the middle of a write
    step_to(1);  raise(1'b1, 13'h1234, 2'd0);
    step_to(12); chk("rw_ra", 32'(RA), 32'h1234);
    step();      chk("rw_rwe13", 32'(RWE), 32'h6);
    step();      chk("rw_rwe14", 32'(RWE), 32'h6);
    #2;
    RES = 1'b0;
    #1;
    chk("rw_async", vec(), rst_vec);
    repeat (2) @(posedge M24);
    #1;
    RES = 1'b1;
    pos = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("rw_post%0d", i), 32'({RWE, CPU_ACK}), 32'({3'b111, 1'b0}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/k052109_vram_sched.md
K052109_VRAM_SCHED -- requirements
Module: k052109_vram_sched

Interface
REQ-001 SHALL have parameter CELL_LEN, default 16: M24 cycles per character cell; fixed at 16 for this revision.
REQ-002 SHALL have parameter SLOT_LEN, default 4: M24 cycles per access slot.
REQ-003 M24  in  1  sole clock; all flops rising-edge.
REQ-004 RES  in  1  asynchronous, active-low reset.
REQ-005 CELL_SYNC  in  1  start-of-cell strobe, sampled on M24.
REQ-006 FETCH_EN  in  1  1 = active display (tile fetch slots used); 0 = blanking.
REQ-007 LA_ADDR  in  13  layer A tile-map address.
REQ-008 LB_ADDR  in  13  layer B tile-map address.
REQ-009 FX_ADDR  in  13  fix layer tile-map address.
REQ-010 CPU_REQ  in  1  CPU VRAM request level (decoded from VCS).
REQ-011 CPU_WR  in  1  1 = write, 0 = read; sampled with request.
REQ-012 CPU_ADDR  in  13  CPU VRAM address; sampled with request.
REQ-013 CPU_BANK  in  2  RAM bank 0..2; 3 = invalid.
REQ-014 RA  out  13  VRAM address.
REQ-015 RCS  out  2  VRAM chip selects, active-low, both driven identically.
REQ-016 ROE  out  3  per-bank output enables, active-low.
REQ-017 RWE  out  3  per-bank write enables, active-low.
REQ-018 LA_LAT, LB_LAT, FX_LAT, CPU_LAT  out  1 each  one-cycle data-capture strobes.
REQ-019 CPU_ACK  out  1  one-cycle completion pulse.
REQ-020 SLOT  out  2  current slot: 0 = LA, 1 = LB, 2 = FX, 3 = CPU.

Function
REQ-021 A 4-bit cell counter SHALL increment every M24 and wrap from 15 to 0; SLOT = counter[3:2]; phase = counter[1:0].
REQ-022 CELL_SYNC=1 SHALL load the counter to 0 on the next edge, overriding the increment.
REQ-023 Phase 0: RA driven with the slot owner's address; RCS/ROE/RWE inactive.
REQ-024 Phases 1-2: RCS=00; fetch reads drive ROE=000 (all banks); CPU read drives ROE low on CPU_BANK only; CPU write drives RWE low on CPU_BANK only.
REQ-025 Phase 2: the owner's *_LAT SHALL be 1 for exactly that cycle.
REQ-026 Phase 3: all strobes inactive; RA SHALL hold its value.
REQ-027 A rising edge of CPU_REQ SHALL capture CPU_WR, CPU_ADDR and CPU_BANK into a single pending register.
REQ-028 A CPU_REQ rise while an access is pending SHALL be ignored; the pending register SHALL NOT be overwritten.
REQ-029 A pending request SHALL be serviced in the next slot whose phase-0 cycle starts after capture. Eligible slots: slot 3 when FETCH_EN=1; any slot when FETCH_EN=0.
REQ-030 FETCH_EN SHALL be sampled at phase 0 and held for the rest of that slot.
REQ-031 An eligible slot with no CPU request pending SHALL be idle (all enables inactive) when FETCH_EN=0.
REQ-032 CPU_ACK SHALL pulse at phase 3 of the serviced slot; the pending register SHALL clear on the same edge.
REQ-033 Worst-case capture-to-ACK latency SHALL be at most CELL_LEN+SLOT_LEN = 20 cycles.
REQ-034 CPU_BANK=3 SHALL run the slot with no ROE/RWE asserted, still pulse CPU_LAT and CPU_ACK, and clear the pending register.
REQ-035 CELL_SYNC during phases 1-3 of a CPU slot SHALL abort the access: strobes deassert next cycle, no ACK, and the request stays pending for retry.
REQ-036 A capture on the same edge as the phase-0 start of an eligible slot SHALL NOT be serviced in that slot.

Reset
REQ-037 While RES=0, outputs SHALL be: counter=0, pending clear, RA=0, RCS=11, ROE=111, RWE=111, all *_LAT=0, CPU_ACK=0, SLOT=0.
REQ-038 CPU_REQ high at reset release SHALL NOT be captured; it must first be seen low.
REQ-039 Reset mid-access SHALL drop all enables immediately (asynchronously).

Structure
REQ-040 Package k052109_pkg SHALL hold the slot enumeration (LA, LB, FX, CPU), the phase constants and the inactive-level constants for RCS, ROE and RWE.
REQ-041 Sub-module k052109_cpu_req SHALL contain edge detection, the pending register and the ACK clear; the top level holds the counter and output decode.

Verification
REQ-042 Reset release, FETCH_EN=1, LA/LB/FX_ADDR=0x0100/0x0900/0x1100, no CPU -> RA sequence repeats every 16 cycles; LAT strobes at cycles 2, 6, 10; ROE=000 in cycles 1-2, 5-6, 9-10.
REQ-043 CPU write, addr 0x1ABC, bank 1, raised at cycle 5 -> RA=0x1ABC at cycle 12; RWE=101 in cycles 13-14; CPU_ACK at cycle 15.
REQ-044 FETCH_EN=0, CPU read, bank 2, raised at cycle 1 -> serviced in slot 1 (cycles 4-7); ROE=011; ACK at cycle 7.
REQ-045 Second CPU_REQ rise, addr 0x0001, while 0x0FFF pending -> only 0x0FFF accessed; one ACK.
REQ-046 CELL_SYNC at cycle 13 during a CPU slot -> no ACK; request retried in the next cell's slot 3.
REQ-047 RES low at cycle 14 of a write -> RWE=111 immediately; no ACK after release.
